rf_write_arb: RTL and testbench

RF_WRITE_ARB -- requirements
Module: rf_write_arb

---
 rtl/rf_write_arb_if.sv | 39 +++
 rtl/rf_write_arb.sv | 86 ++++++++
 tb/tb_rf_write_arb.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rf_write_arb_if.sv
// Write-arbiter bus: two writeback requesters in, one register-file write port out.
// The slave modport is the arbiter's view; master is the environment's view.
interface rf_write_arb_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;

   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      output req0_ready,
      input  req1_valid, req1_addr, req1_data,
      output req1_ready,
      output wr_en, wr_addr, wr_data,
      input  wr_ready
   );

   modport master (
      output req0_valid, req0_addr, req0_data,
      input  req0_ready,
      output req1_valid, req1_addr, req1_data,
      input  req1_ready,
      input  wr_en, wr_addr, wr_data,
      output wr_ready
   );
endinterface

// File: rtl/rf_write_arb.sv
// Register-file write arbiter: picks one of two writeback requesters (ALU, load)
// and holds the winner in a single output slot that drives the 5:32 write decoder.
// Writes to the zero register (address all ones) are accepted and silently dropped.
// Optional macro RF_WRITE_ARB_RR_EN: round-robin on contention; otherwise the load
// requester (1) always wins.
module rf_write_arb #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic          clk,
   input  logic          reset,
   rf_write_arb_if.slave bus
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

   slot_state_t       state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] data_reg;
   logic              prio_reg;       // 1: requester 1 wins when both are valid

   logic              slot_free;
   logic              sel1;
   logic              ready0, ready1;
   logic              accept;
   logic              both_valid;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_data;
   logic              load;

   // Grant selection, handshake and slot next-state
   always_comb begin
      state_next = state_reg;
      slot_free  = (state_reg == EMPTY) || bus.wr_ready;
      both_valid = bus.req0_valid && bus.req1_valid;
      sel1       = bus.req1_valid && (!bus.req0_valid || prio_reg);
      ready0     = slot_free && !reset && !sel1;
      ready1     = slot_free && !reset && sel1;
      accept     = (bus.req0_valid && ready0) || (bus.req1_valid && ready1);
      acc_addr   = sel1 ? bus.req1_addr : bus.req0_addr;
      acc_data   = sel1 ? bus.req1_data : bus.req0_data;
      // zero-register writes complete the handshake but never occupy the slot
      load       = accept && (acc_addr != {ADDR_W{1'b1}});

      case (state_reg)
         EMPTY: if (load) state_next = FULL;
         FULL:  if (bus.wr_ready && !load) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   // Slot occupancy register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= EMPTY;
      else       state_reg <= state_next;
   end

   // Slot payload: only a non-zero-register accept overwrites it, so it holds under backpressure
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_reg <= '0;
         data_reg <= '0;
      end else if (load) begin
         addr_reg <= acc_addr;
         data_reg <= acc_data;
      end
   end

`ifdef RF_WRITE_ARB_RR_EN
   // Round-robin pointer: flip after every grant made under contention
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    prio_reg <= 1'b0;
      else if (both_valid && accept) prio_reg <= ~prio_reg;
   end
`else
   // Fixed priority: load writeback always wins contention
   assign prio_reg = 1'b1;
`endif

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.wr_en      = (state_reg == FULL);
   assign bus.wr_addr    = addr_reg;
   assign bus.wr_data    = data_reg;

endmodule

// File: tb/tb_rf_write_arb.sv
// Directed testbench for rf_write_arb: reset state, single write, zero-register drop,
// contention (round-robin or fixed priority), backpressure and asynchronous reset.
module tb_rf_write_arb;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;

   logic clk;
   logic reset;

   int n_cmp;
   int n_bad;

   rf_write_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

   rf_write_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h @%0t", tag, obs, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus_if.req0_valid = v;
      bus_if.req0_addr  = a;
      bus_if.req0_data  = d;
   endtask

   task automatic drive1(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus_if.req1_valid = v;
      bus_if.req1_addr  = a;
      bus_if.req1_data  = d;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      drive0(1'b0, '0, '0);
      drive1(1'b0, '0, '0);
      bus_if.wr_ready = 1'b1;

      // reset state, with a requester valid to show ready is held low
      step();
      drive0(1'b1, 5'd4, 64'h1);
      @(negedge clk);
      check_val("rst_wr_en",   bus_if.wr_en, 0);
      check_val("rst_wr_addr", bus_if.wr_addr, 0);
      check_val("rst_wr_data", bus_if.wr_data, 0);
      check_val("rst_ready0",  bus_if.req0_ready, 0);
      check_val("rst_ready1",  bus_if.req1_ready, 0);
      drive0(1'b0, '0, '0);
      reset = 1'b0;
      step();
      check_val("post_rst_wr_en", bus_if.wr_en, 0);

      // single write
      drive0(1'b1, 5'd5, 64'hAA);
      @(negedge clk);
      check_val("single_ready0", bus_if.req0_ready, 1);
      check_val("single_ready1", bus_if.req1_ready, 0);
      step();
      drive0(1'b0, '0, '0);
      check_val("single_wr_en",   bus_if.wr_en, 1);
      check_val("single_wr_addr", bus_if.wr_addr, 5);
      check_val("single_wr_data", bus_if.wr_data, 64'hAA);
      step();
      check_val("single_drain", bus_if.wr_en, 0);

      // zero-register write is accepted but not issued
      drive1(1'b1, 5'd31, 64'h55);
      @(negedge clk);
      check_val("xzr_ready1", bus_if.req1_ready, 1);
      check_val("xzr_ready0", bus_if.req0_ready, 0);
      step();
      drive1(1'b0, '0, '0);
      check_val("xzr_wr_en", bus_if.wr_en, 0);

      // contention: both valid for four cycles
      drive0(1'b1, 5'd1, 64'h10);
      drive1(1'b1, 5'd2, 64'h20);
      for (int i = 0; i < 4; i++) begin
         logic g1;
`ifdef RF_WRITE_ARB_RR_EN
         g1 = (i % 2) == 1;
`else
         g1 = 1'b1;
`endif
         @(negedge clk);
         check_val($sformatf("cont%0d_ready0", i), bus_if.req0_ready, {63'd0, ~g1});
         check_val($sformatf("cont%0d_ready1", i), bus_if.req1_ready, {63'd0, g1});
         step();
         check_val($sformatf("cont%0d_wr_addr", i), bus_if.wr_addr, g1 ? 64'd2 : 64'd1);
         check_val($sformatf("cont%0d_wr_data", i), bus_if.wr_data, g1 ? 64'h20 : 64'h10);
      end
      drive0(1'b0, '0, '0);
      drive1(1'b0, '0, '0);
      step();
      check_val("cont_drain", bus_if.wr_en, 0);

      // backpressure: fill slot with addr 7, then hold wr_ready low
      bus_if.wr_ready = 1'b0;
      drive0(1'b1, 5'd7, 64'h77);
      @(negedge clk);
      check_val("bp_fill_ready0", bus_if.req0_ready, 1);
      step();
      drive0(1'b1, 5'd9, 64'h99);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val($sformatf("bp%0d_ready0", i), bus_if.req0_ready, 0);
         step();
         check_val($sformatf("bp%0d_wr_en", i),   bus_if.wr_en, 1);
         check_val($sformatf("bp%0d_wr_addr", i), bus_if.wr_addr, 7);
         check_val($sformatf("bp%0d_wr_data", i), bus_if.wr_data, 64'h77);
      end
      bus_if.wr_ready = 1'b1;
      @(negedge clk);
      check_val("bp_release_ready0", bus_if.req0_ready, 1);
      step();
      drive0(1'b0, '0, '0);
      check_val("bp_b2b_wr_en",   bus_if.wr_en, 1);
      check_val("bp_b2b_wr_addr", bus_if.wr_addr, 9);
      check_val("bp_b2b_wr_data", bus_if.wr_data, 64'h99);

      // slot drains while a zero-register write is accepted on the same edge
      drive1(1'b1, 5'd31, 64'h5);
      @(negedge clk);
      check_val("xzr_full_ready1", bus_if.req1_ready, 1);
      step();
      drive1(1'b0, '0, '0);
      check_val("xzr_full_wr_en", bus_if.wr_en, 0);

      // asynchronous reset while FULL
      bus_if.wr_ready = 1'b0;
      drive0(1'b1, 5'd3, 64'h33);
      step();
      drive0(1'b0, '0, '0);
      check_val("ar_full_wr_en", bus_if.wr_en, 1);
      #2;
      reset = 1'b1;
      #1;
      check_val("ar_wr_en",   bus_if.wr_en, 0);
      check_val("ar_wr_addr", bus_if.wr_addr, 0);
      check_val("ar_wr_data", bus_if.wr_data, 0);
      step();
      reset = 1'b0;
      bus_if.wr_ready = 1'b1;
      step();
      check_val("ar_after1_wr_en", bus_if.wr_en, 0);
      step();
      check_val("ar_after2_wr_en", bus_if.wr_en, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
